// File: rtl/wishbone_pkg.sv
// Shared types and width helpers for the Wishbone slave transactor.
package wishbone_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = DAT_W / 8;

    // One captured bus request, in the order presented to the client.
    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Bits needed for a counter spanning 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO with flush; a pop frees a slot for a push in the same cycle.
module wb_sync_fifo
    import wishbone_pkg::clog2;
    import wishbone_pkg::cnt_width;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [WIDTH-1:0] din,
    input  logic             deq,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] rd_q, rd_d;
    logic [IDX_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_enq;
    logic             do_deq;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign head   = mem_q[rd_q];
    assign do_deq = deq & ~empty;
    assign do_enq = enq & (~full | do_deq);

    // Pointer and occupancy update; flush wins over everything.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_deq) begin
                rd_d = rd_q + IDX_W'(1);
            end
            if (do_enq) begin
                wr_d = wr_q + IDX_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_enq && !flush) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/wishbone_slave_xactor.sv
// Wishbone B4 pipelined slave: bus cycles become a client request stream,
// client responses become ACK_O/DAT_O in request order.
module wishbone_slave_xactor
    import wishbone_pkg::cnt_width;
#(
    parameter int unsigned ADR_W           = 32,
    parameter int unsigned DAT_W           = 32,
    parameter int unsigned SEL_W           = 4,
    parameter int unsigned REQ_DEPTH       = 2,
    parameter int unsigned RSP_DEPTH       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CYC_I,
    input  logic                         STB_I,
    input  logic                         WE_I,
    input  logic [ADR_W-1:0]             ADR_I,
    input  logic [SEL_W-1:0]             SEL_I,
    input  logic [DAT_W-1:0]             DAT_I,
    output logic                         STALL_O,
    output logic                         ACK_O,
    output logic [DAT_W-1:0]             DAT_O,
    output logic [SEL_W+ADR_W+DAT_W:0]   client_request_get,
    output logic                         RDY_client_request_get,
    input  logic                         EN_client_request_get,
    input  logic [DAT_W-1:0]             client_response_put,
    output logic                         RDY_client_response_put,
    input  logic                         EN_client_response_put
);

    localparam int unsigned REQ_W = 1 + SEL_W + ADR_W + DAT_W;
    localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

    logic             req_full, req_empty;
    logic             rsp_full, rsp_empty;
    logic [DAT_W-1:0] rsp_head;

    logic             accept, deq_fire, abort;
    logic             put_seen, put_ok, rsp_enq, rsp_deq;

    logic [CNT_W-1:0] out_q,  out_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic [CNT_W-1:0] disc_q, disc_d;
    logic             ack_q,  ack_d;
    logic [DAT_W-1:0] dat_q,  dat_d;

    // Bus-side handshake and client-side qualifiers.
    assign STALL_O  = req_full | (out_q == CNT_W'(MAX_OUTSTANDING)) | (disc_q != '0);
    assign accept   = CYC_I & STB_I & ~STALL_O;
    assign deq_fire = EN_client_request_get & ~req_empty;
    assign abort    = ~CYC_I & ((out_q != '0) | ~rsp_empty);
    assign put_seen = EN_client_response_put & ~rsp_full;
    // A put is only meaningful for a request the client actually holds;
    // stale puts (e.g. after reset) are dropped.
    assign put_ok   = put_seen & (disc_q == '0) & ((infl_q != '0) | deq_fire);
    assign rsp_enq  = put_ok & ~abort;
    assign rsp_deq  = CYC_I & ~rsp_empty;

    assign RDY_client_request_get  = ~req_empty;
    assign RDY_client_response_put = ~rsp_full;
    assign ACK_O = ack_q;
    assign DAT_O = dat_q;

    wb_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (CLK),
        .rst   (RST),
        .enq   (accept),
        .din   ({WE_I, SEL_I, ADR_I, DAT_I}),
        .deq   (deq_fire),
        .flush (abort),
        .full  (req_full),
        .empty (req_empty),
        .head  (client_request_get)
    );

    wb_sync_fifo #(
        .WIDTH (DAT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (CLK),
        .rst   (RST),
        .enq   (rsp_enq),
        .din   (client_response_put),
        .deq   (rsp_deq),
        .flush (abort),
        .full  (rsp_full),
        .empty (rsp_empty),
        .head  (rsp_head)
    );

    // Counter bookkeeping, ACK generation and abort handling.
    always_comb begin
        out_d  = out_q;
        infl_d = infl_q;
        disc_d = disc_q;
        ack_d  = rsp_deq;
        dat_d  = rsp_deq ? rsp_head : '0;
        if (abort) begin
            // Whatever the client still holds must be answered and dropped.
            out_d  = '0;
            infl_d = '0;
            disc_d = infl_q + CNT_W'(deq_fire) - CNT_W'(put_ok);
            ack_d  = 1'b0;
            dat_d  = '0;
        end else begin
            out_d  = out_q + CNT_W'(accept) - CNT_W'(ack_q);
            infl_d = infl_q + CNT_W'(deq_fire) - CNT_W'(put_ok);
            if ((disc_q != '0) && put_seen) begin
                disc_d = disc_q - CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q  <= '0;
            infl_q <= '0;
            disc_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            out_q  <= out_d;
            infl_q <= infl_d;
            disc_q <= disc_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
        end
    end

    // Client must not pop an empty request stream.
    a_pop_when_empty: assert property (@(posedge CLK) disable iff (RST)
        EN_client_request_get |-> RDY_client_request_get);

    // Outstanding count stays within its limit.
    a_out_bound: assert property (@(posedge CLK) disable iff (RST)
        out_q <= CNT_W'(MAX_OUTSTANDING));

endmodule
